plateau_detector_v2: RTL and testbench
======================================

PLATEAU_DETECTOR_V2 -- requirements
Module: plateau_detector_v2

Interface
REQ-001 The block SHALL provide these parameters (name, default, meaning):
- WIDTH, 16: metric and phase sample width.
- THRESHOLD, 1: metric must strictly exceed this to count as in-burst.
- RISE_MARGIN, 100: metric increase that counts as still rising.
- SETTLE_LEN, 3: consecutive non-rising samples that confirm the edge.
- PLATEAU_LEN, 90: plateau_cnt value that must be exceeded to declare a plateau.
- FRAME_OFFSET, 128: trigger-count value at which the trigger fires.
- PHASE_SHIFT, 5: right shift applied to phase (divide by 2^PHASE_SHIFT).
- AVG_LOG2, 3: phase averaging depth, 2^AVG_LOG2 samples.

REQ-002 The block SHALL provide these ports (name, direction, width, meaning):
- clk, in, 1: the single clock.
- reset, in, 1: synchronous, active-high reset.
- clear, in, 1: synchronous, active-high soft reset, same effect as reset.
- i0_tdata/i0_tlast/i0_tvalid, in, WIDTH/1/1: correlation metric stream. i0_tready, out, 1.
- i1_tdata/i1_tlast/i1_tvalid, in, WIDTH/1/1: accumulated phase stream. i1_tready, out, 1.
- o_tdata, out, WIDTH: phase estimate. o_tlast, out, 1: frame-start strobe. o_tvalid, out, 1. o_tready, in, 1.
- lost_cnt, out, 16: count of aborted detections, saturating.

Function
REQ-003 do_op SHALL equal i0_tvalid & i1_tvalid & o_tready; i0_tready and i1_tready SHALL equal do_op.
REQ-004 o_tvalid SHALL equal i0_tvalid & i1_tvalid; o_tdata SHALL be the registered phase estimate.
REQ-005 The state machine and all counters SHALL advance only on cycles with do_op=1; with do_op=0 all state SHALL hold.
REQ-006 Comparisons against max_val+RISE_MARGIN SHALL be evaluated at WIDTH+1 bits, so the sum never wraps.
REQ-007 The states SHALL be IDLE, RISE, SETTLE, PLATEAU and OFFSET.
REQ-008 In IDLE, thresh_met SHALL move the machine to RISE and load max_val with i0_tdata.
REQ-009 In RISE, SETTLE and PLATEAU, !thresh_met SHALL:
- return the machine to IDLE;
- zero plateau_cnt, settle_cnt, trig_cnt and max_val;
- increment lost_cnt, saturating at 0xFFFF.
REQ-010 In RISE, i0_tdata > max_val+RISE_MARGIN SHALL update max_val; otherwise the machine SHALL move to SETTLE with settle_cnt=0.
REQ-011 In SETTLE, a rising sample SHALL update max_val and return the machine to RISE.
REQ-012 In SETTLE, when settle_cnt==SETTLE_LEN-1 on a non-rising sample, the machine SHALL enter PLATEAU and capture the phase (REQ-019).
REQ-013 plateau_cnt SHALL increment on every do_op in RISE, SETTLE and PLATEAU, and SHALL saturate at all-ones.
REQ-014 In PLATEAU, plateau_cnt > PLATEAU_LEN SHALL move the machine to OFFSET.
REQ-015 trig_cnt SHALL increment on every do_op in PLATEAU and OFFSET.
REQ-016 In OFFSET, thresh_met SHALL be ignored.
REQ-017 In OFFSET, when trig_cnt==FRAME_OFFSET:
- o_tlast SHALL assert for exactly one transferred beat;
- the machine SHALL return to IDLE with all counters zeroed.
REQ-018 o_tlast SHALL deassert on the do_op following its assertion and SHALL hold while do_op=0; it SHALL never be dropped untransferred.
REQ-019 Phase capture SHALL be i1_tdata arithmetically shifted right by PHASE_SHIFT; the phase estimate SHALL hold until the next capture.
REQ-020 When reset/clear coincides with any event (including a trigger), reset/clear SHALL win.

Reset
REQ-021 On reset or clear:
- state SHALL be IDLE;
- max_val, counters, lost_cnt and the phase estimate SHALL be 0;
- o_tlast SHALL be 0.
REQ-022 Outputs after reset SHALL be o_tdata=0, o_tlast=0, lost_cnt=0; o_tvalid and the treadys SHALL follow REQ-003/004 combinationally.

Configuration
REQ-023 The macro PLATEAU_DET_PHASE_AVG_EN SHALL select the phase-capture mode.
- Defined: from PLATEAU entry, the block SHALL sum 2^AVG_LOG2 shifted phase samples in a WIDTH+AVG_LOG2-bit accumulator, then load the sum >>AVG_LOG2 as the phase estimate.
- Defined: if the plateau aborts before the sum completes, the phase estimate SHALL remain unchanged.
- Undefined: the phase estimate SHALL be the single sample captured at PLATEAU entry.

Verification
REQ-024 The bench SHALL cover these directed scenarios (defaults):
- Metric 0,0,500,700,900,905×200 with phase 3200 throughout, o_tready=1 -> exactly one o_tlast pulse, FRAME_OFFSET+1 do_op after PLATEAU entry; o_tdata=100 (both macro settings).
- Same stimulus with o_tready toggling 50% -> identical o_tlast beat index counted in transfers; no duplicated or lost strobe.
- Metric drops to 0 during PLATEAU at plateau_cnt=40 -> no o_tlast; lost_cnt=1; IDLE next cycle.
- WIDTH=16, metric 65500 then 65535 -> no wrap, treated as non-rising; machine enters SETTLE.
- clear asserted in OFFSET at trig_cnt=127 -> no o_tlast; all outputs 0.
- PLATEAU_DET_PHASE_AVG_EN defined, phase 3200,3232,... rising by 32 -> o_tdata=103 (mean of 100..107 floored).

Source files
------------

// File: rtl/plateau_detector_v2.sv
// plateau_detector_v2
//   Finds the plateau of a correlation metric burst and, FRAME_OFFSET
//   transfers into the plateau, emits a one-beat frame-start strobe. The
//   phase sample taken at plateau entry (shifted right by PHASE_SHIFT) is
//   presented as the phase estimate.
//
//   Optional feature macro: PLATEAU_DET_PHASE_AVG_EN
//     defined   - phase estimate is the mean of 2^AVG_LOG2 shifted samples
//                 starting at plateau entry; an aborted plateau leaves the
//                 previous estimate untouched.
//     undefined - phase estimate is the single sample at plateau entry.
//
// Ports
//   clk, reset, clear      : clock, synchronous active-high reset / soft reset
//   i0_t*                  : correlation metric stream (tlast unused)
//   i1_t*                  : accumulated phase stream (tlast unused)
//   o_tdata/o_tlast/o_t*   : phase estimate, frame-start strobe, handshake
//   lost_cnt               : saturating count of aborted detections
module plateau_detector_v2 #(
    parameter int WIDTH        = 16,
    parameter int THRESHOLD    = 1,
    parameter int RISE_MARGIN  = 100,
    parameter int SETTLE_LEN   = 3,
    parameter int PLATEAU_LEN  = 90,
    parameter int FRAME_OFFSET = 128,
    parameter int PHASE_SHIFT  = 5,
    parameter int AVG_LOG2     = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [WIDTH-1:0] i0_tdata,
    input  logic             i0_tlast,
    input  logic             i0_tvalid,
    output logic             i0_tready,
    input  logic [WIDTH-1:0] i1_tdata,
    input  logic             i1_tlast,
    input  logic             i1_tvalid,
    output logic             i1_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             o_tready,
    output logic [15:0]      lost_cnt
);

    typedef enum logic [2:0] {IDLE, RISE, SETTLE, PLATEAU, OFFSET} state_t;

    localparam logic [WIDTH-1:0] THRESH_V    = WIDTH'(THRESHOLD);
    localparam logic [WIDTH:0]   MARGIN_V    = (WIDTH+1)'(RISE_MARGIN);
    localparam logic [WIDTH-1:0] SETTLE_LAST = WIDTH'(SETTLE_LEN - 1);
    localparam logic [WIDTH-1:0] PLATEAU_V   = WIDTH'(PLATEAU_LEN);
    localparam logic [WIDTH-1:0] OFFSET_V    = WIDTH'(FRAME_OFFSET);

    state_t                  state;
    logic [WIDTH-1:0]        max_val;
    logic [WIDTH-1:0]        settle_cnt;
    logic [WIDTH-1:0]        plateau_cnt;
    logic [WIDTH-1:0]        trig_cnt;
    logic [WIDTH-1:0]        phase_est;
    logic                    tlast_r;

    logic                    do_op;
    logic                    thresh_met;
    logic                    rising;
    logic signed [WIDTH-1:0] phase_smp;
    logic                    unused_tlast;

    assign do_op      = i0_tvalid & i1_tvalid & o_tready;
    assign i0_tready  = do_op;
    assign i1_tready  = do_op;
    assign o_tvalid   = i0_tvalid & i1_tvalid;
    assign o_tdata    = phase_est;
    assign o_tlast    = tlast_r;

    assign thresh_met = i0_tdata > THRESH_V;
    // One extra bit so max_val + margin can never wrap around.
    assign rising     = {1'b0, i0_tdata} > ({1'b0, max_val} + MARGIN_V);
    assign phase_smp  = $signed(i1_tdata) >>> PHASE_SHIFT;

    assign unused_tlast = i0_tlast ^ i1_tlast;

`ifdef PLATEAU_DET_PHASE_AVG_EN
    localparam int unsigned       ACC_W    = WIDTH + AVG_LOG2;
    localparam int unsigned       AVG_N    = 1 << AVG_LOG2;
    localparam logic [AVG_LOG2:0] AVG_LAST = (AVG_LOG2+1)'(AVG_N - 1);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] smp_ext;
    logic signed [ACC_W-1:0] avg_sum;
    logic [AVG_LOG2:0]       avg_cnt;
    logic                    avg_busy;
    logic                    avg_step;

    assign smp_ext  = ACC_W'(phase_smp);
    assign avg_sum  = acc + smp_ext;
    // The sample that aborts a plateau is not part of the average.
    assign avg_step = avg_busy &&
                      ((state == OFFSET) || ((state == PLATEAU) && thresh_met));
`endif

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state       <= IDLE;
            max_val     <= '0;
            settle_cnt  <= '0;
            plateau_cnt <= '0;
            trig_cnt    <= '0;
            phase_est   <= '0;
            tlast_r     <= 1'b0;
            lost_cnt    <= '0;
`ifdef PLATEAU_DET_PHASE_AVG_EN
            acc         <= '0;
            avg_cnt     <= '0;
            avg_busy    <= 1'b0;
`endif
        end else if (do_op) begin
            // A pending strobe is consumed by this transfer.
            tlast_r <= 1'b0;

`ifdef PLATEAU_DET_PHASE_AVG_EN
            if (avg_step) begin
                if (avg_cnt == AVG_LAST) begin
                    phase_est <= WIDTH'(avg_sum >>> AVG_LOG2);
                    avg_busy  <= 1'b0;
                end else begin
                    acc     <= avg_sum;
                    avg_cnt <= avg_cnt + 1'b1;
                end
            end
`endif

            case (state)
                IDLE: begin
                    if (thresh_met) begin
                        state   <= RISE;
                        max_val <= i0_tdata;
                    end
                end

                RISE, SETTLE, PLATEAU: begin
                    if (!thresh_met) begin
                        state       <= IDLE;
                        max_val     <= '0;
                        settle_cnt  <= '0;
                        plateau_cnt <= '0;
                        trig_cnt    <= '0;
                        if (lost_cnt != 16'hFFFF)
                            lost_cnt <= lost_cnt + 16'd1;
`ifdef PLATEAU_DET_PHASE_AVG_EN
                        avg_busy    <= 1'b0;
`endif
                    end else begin
                        if (plateau_cnt != '1)
                            plateau_cnt <= plateau_cnt + 1'b1;

                        if (state == RISE) begin
                            if (rising) begin
                                max_val <= i0_tdata;
                            end else begin
                                state      <= SETTLE;
                                settle_cnt <= '0;
                            end
                        end else if (state == SETTLE) begin
                            if (rising) begin
                                max_val <= i0_tdata;
                                state   <= RISE;
                            end else if (settle_cnt == SETTLE_LAST) begin
                                state <= PLATEAU;
`ifdef PLATEAU_DET_PHASE_AVG_EN
                                if (AVG_N == 1) begin
                                    phase_est <= phase_smp;
                                end else begin
                                    acc      <= smp_ext;
                                    avg_cnt  <= (AVG_LOG2+1)'(1);
                                    avg_busy <= 1'b1;
                                end
`else
                                phase_est <= phase_smp;
`endif
                            end else begin
                                settle_cnt <= settle_cnt + 1'b1;
                            end
                        end else begin
                            trig_cnt <= trig_cnt + 1'b1;
                            if (plateau_cnt > PLATEAU_V)
                                state <= OFFSET;
                        end
                    end
                end

                OFFSET: begin
                    if (trig_cnt == OFFSET_V) begin
                        state       <= IDLE;
                        tlast_r     <= 1'b1;
                        max_val     <= '0;
                        settle_cnt  <= '0;
                        plateau_cnt <= '0;
                        trig_cnt    <= '0;
`ifdef PLATEAU_DET_PHASE_AVG_EN
                        avg_busy    <= 1'b0;
`endif
                    end else begin
                        trig_cnt <= trig_cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_plateau_detector_v2.sv
// tb_plateau_detector_v2
//   Directed scoreboard bench for plateau_detector_v2 (default parameters).
//   The driver pushes the expected output beat for every transfer it issues;
//   a negedge monitor pops and compares whenever a transfer occurs.
//   Expectations follow PLATEAU_DET_PHASE_AVG_EN when it is defined.
module tb_plateau_detector_v2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic [15:0] i0_tdata = '0;
    logic        i0_tlast = 1'b0;
    logic        i0_tvalid = 1'b0;
    logic        i0_tready;
    logic [15:0] i1_tdata = '0;
    logic        i1_tlast = 1'b0;
    logic        i1_tvalid = 1'b0;
    logic        i1_tready;
    logic [15:0] o_tdata;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready = 1'b0;
    logic [15:0] lost_cnt;

    plateau_detector_v2 #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .i0_tdata(i0_tdata), .i0_tlast(i0_tlast), .i0_tvalid(i0_tvalid), .i0_tready(i0_tready),
        .i1_tdata(i1_tdata), .i1_tlast(i1_tlast), .i1_tvalid(i1_tvalid), .i1_tready(i1_tready),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
        .lost_cnt(lost_cnt)
    );

    always #5 clk = ~clk;

`ifdef PLATEAU_DET_PHASE_AVG_EN
    localparam int VIS_BURST = 16;    // first beat showing the 8-sample mean
    localparam int VIS_WRAP  = 12;
    localparam int RAMP_VAL  = 103;   // floor(mean(100..107))
`else
    localparam int VIS_BURST = 9;     // first beat after the plateau-entry capture
    localparam int VIS_WRAP  = 5;
    localparam int RAMP_VAL  = 100;
`endif

    typedef struct packed {
        logic        tlast;
        logic [15:0] tdata;
        int          scen;
        int          idx;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: handshake relations every cycle, data/strobe on each transfer.
    always @(negedge clk) begin
        logic v;
        exp_t e;
        v = i0_tvalid & i1_tvalid;
        chk("handshake", {29'd0, o_tvalid, i0_tready, i1_tready},
            {29'd0, v, v & o_tready, v & o_tready});
        if (v && o_tready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_beat", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk($sformatf("s%0d_t%0d_tdata", e.scen, e.idx), {16'd0, o_tdata}, {16'd0, e.tdata});
                chk($sformatf("s%0d_t%0d_tlast", e.scen, e.idx), {31'd0, o_tlast}, {31'd0, e.tlast});
            end
        end
    end

    // One beat; in stall mode a hold cycle precedes it (ready low on odd
    // beats, valids low on even beats), giving 50% o_tready activity.
    task automatic send(input int scen, input int idx, input logic [15:0] m, input logic [15:0] p,
                        input logic exp_l, input logic [15:0] exp_d, input bit clr, input bit stall);
        exp_t e;
        i0_tdata = m;
        i1_tdata = p;
        if (stall) begin
            if (idx % 2 == 1) begin
                i0_tvalid = 1'b1; i1_tvalid = 1'b1; o_tready = 1'b0;
            end else begin
                i0_tvalid = 1'b0; i1_tvalid = 1'b0; o_tready = 1'b1;
            end
            @(posedge clk); #1;
        end
        i0_tvalid = 1'b1; i1_tvalid = 1'b1; o_tready = 1'b1;
        clear = clr;
        e.tlast = exp_l; e.tdata = exp_d; e.scen = scen; e.idx = idx;
        sb.push_back(e);
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    task automatic go_idle();
        i0_tvalid = 1'b0; i1_tvalid = 1'b0; o_tready = 1'b1; clear = 1'b0;
        @(negedge clk);
        chk("sb_drained", sb.size(), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        i0_tvalid = 1'b0; i1_tvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_tdata", {16'd0, o_tdata}, 32'd0);
        chk("rst_tlast", {31'd0, o_tlast}, 32'd0);
        chk("rst_lost", {16'd0, lost_cnt}, 32'd0);
    endtask

    // Metric 0,0,500,700,900,905... Plateau entry is beat 8, the trigger
    // fires on beat 137 (trig_cnt=128) and the strobe rides beat 138.
    task automatic run_burst(input int scen, input bit stall, input int n, input int step,
                             input int clr_at, input int abort_at);
        for (int t = 0; t < n; t++) begin
            logic [15:0] m, p, d;
            logic        l;
            int          val;
            case (t)
                0, 1:    m = 16'd0;
                2:       m = 16'd500;
                3:       m = 16'd700;
                4:       m = 16'd900;
                default: m = 16'd905;
            endcase
            if (abort_at >= 0 && t >= abort_at) m = 16'd0;
            p   = 16'(3200 + ((t < 8) ? 0 : step * (t - 8)));
            val = (step != 0) ? RAMP_VAL : 100;
            l   = (clr_at < 0) && (abort_at < 0) && (t == 138);
            d   = (t >= VIS_BURST) ? 16'(val) : 16'd0;
            send(scen, t, m, p, l, d, (t == clr_at), stall);
        end
        go_idle();
    endtask

    initial begin
        do_reset();

        // 1: full burst, continuous flow.
        run_burst(1, 1'b0, 205, 0, -1, -1);
        chk("s1_lost", {16'd0, lost_cnt}, 32'd0);
        chk("s1_tlast_after", {31'd0, o_tlast}, 32'd0);
        do_reset();

        // 2: same burst with backpressure / valid gaps.
        run_burst(2, 1'b1, 205, 0, -1, -1);
        chk("s2_lost", {16'd0, lost_cnt}, 32'd0);
        do_reset();

        // 3: metric drops at plateau_cnt=40 (beat 43), stays low.
        run_burst(3, 1'b0, 48, 0, -1, 43);
        chk("s3_lost", {16'd0, lost_cnt}, 32'd1);
        chk("s3_tdata_held", {16'd0, o_tdata}, 32'd100);
        do_reset();

        // 4: 65500 then 65535 must be non-rising (no wrap) -> plateau reached.
        for (int t = 0; t < 14; t++)
            send(4, t, (t == 0) ? 16'd65500 : 16'd65535, 16'd6400, 1'b0,
                 (t >= VIS_WRAP) ? 16'd200 : 16'd0, 1'b0, 1'b0);
        go_idle();
        chk("s4_lost", {16'd0, lost_cnt}, 32'd0);
        do_reset();

        // 5: clear at trig_cnt=127 (beat 136).
        run_burst(5, 1'b0, 137, 0, 136, -1);
        repeat (2) @(negedge clk);
        chk("s5_tdata", {16'd0, o_tdata}, 32'd0);
        chk("s5_tlast", {31'd0, o_tlast}, 32'd0);
        chk("s5_lost", {16'd0, lost_cnt}, 32'd0);

        // 7: clear coinciding with the trigger beat (trig_cnt=128).
        run_burst(7, 1'b0, 138, 0, 137, -1);
        repeat (2) @(negedge clk);
        chk("s7_tdata", {16'd0, o_tdata}, 32'd0);
        chk("s7_tlast", {31'd0, o_tlast}, 32'd0);
        do_reset();

        // 6: phase ramp 3200,3232,... from plateau entry.
        run_burst(6, 1'b0, 30, 32, -1, -1);
        chk("s6_tdata", {16'd0, o_tdata}, 32'(RAMP_VAL));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
